// File: rtl/mcu_pkg.sv
// Shared constants, types and helpers for the mcu I/O ring.
package mcu_pkg;

    localparam int unsigned RST_CYCLES_DEF   = 16;
    localparam int unsigned BREAK_CYCLES_DEF = 1000000;
    localparam int unsigned QD_W             = 4;

    localparam logic IDLE_CS_N = 1'b1;
    localparam logic IDLE_SCLK = 1'b0;
    localparam logic IDLE_TXD  = 1'b1;

    // Flash pin group as seen from the core side, before reset gating.
    typedef struct packed {
        logic            sclk;
        logic            cs_n;
        logic [QD_W-1:0] oe;
        logic [QD_W-1:0] qdo;
    } spi_pins_t;

    localparam spi_pins_t SPI_IDLE = '{
        sclk: IDLE_SCLK,
        cs_n: IDLE_CS_N,
        oe:   '0,
        qdo:  '0
    };

    // Number of bits needed to hold values 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous clear to a configurable value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcu_ring.sv
// I/O ring around the mcu core: reset conditioning with UART-break restart,
// rxd synchronization/deglitch, quad-SPI pad steering and safe idle levels.
module mcu_ring
    import mcu_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
    parameter int unsigned BREAK_CYCLES = BREAK_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            pad_rxd,
    output logic            pad_txd,
    output logic            pad_sclk,
    output logic            pad_cs_n,
    inout  wire  [QD_W-1:0] pad_qd,
    output logic            core_rst_n,
    output logic            core_rxd,
    input  logic            core_txd,
    input  logic            core_sclk,
    input  logic            core_cs_n,
    input  logic [QD_W-1:0] core_qdo,
    input  logic [QD_W-1:0] core_oe,
    output logic [QD_W-1:0] core_qdi,
    output logic            brk_seen
);

    localparam int unsigned SW = clog2(RST_CYCLES + 1);
    localparam int unsigned BW = clog2(BREAK_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_MAX = SW'(RST_CYCLES);
    localparam logic [BW-1:0] BREAK_MAX   = BW'(BREAK_CYCLES);

    logic            rst_sync;
    logic            rxd_s2;
    logic [2:0]      rxd_hist;
    logic            rxd_q;
    logic [BW-1:0]   brk_cnt;
    logic            brk_active;
    logic [SW-1:0]   stretch_cnt;
    logic            core_rst_d;
    logic            rst_q;
    logic            txd_q;
    logic            brk_seen_q;
    spi_pins_t       spi_core;
    spi_pins_t       spi_pad;

    sync2 #(.RST_VAL(1'b0)) u_rst_sync (
        .clk   (clk),
        .rst_n (arstn),
        .d     (1'b1),
        .q     (rst_sync)
    );

    sync2 #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk   (clk),
        .rst_n (arstn),
        .d     (pad_rxd),
        .q     (rxd_s2)
    );

    // 3-sample majority filter: a single-sample glitch never propagates.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rxd_hist <= '1;
            rxd_q    <= 1'b1;
        end else begin
            rxd_hist <= {rxd_hist[1:0], rxd_s2};
            rxd_q    <= (rxd_hist[0] & rxd_hist[1]) |
                        (rxd_hist[0] & rxd_hist[2]) |
                        (rxd_hist[1] & rxd_hist[2]);
        end
    end

    assign brk_active = (brk_cnt == BREAK_MAX);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            brk_cnt <= '0;
        end else if (rxd_q) begin
            brk_cnt <= '0;
        end else if (!brk_active) begin
            brk_cnt <= brk_cnt + BW'(1);
        end
    end

    // Stretch counter restarts on any reset cause and saturates at full count.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stretch_cnt <= '0;
        end else if (!rst_sync || brk_active) begin
            stretch_cnt <= '0;
        end else if (stretch_cnt != STRETCH_MAX) begin
            stretch_cnt <= stretch_cnt + SW'(1);
        end
    end

    // Masking with brk_active drops core reset on the edge right after a break.
    assign core_rst_d = (stretch_cnt == STRETCH_MAX) && !brk_active;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rst_q      <= 1'b0;
            txd_q      <= IDLE_TXD;
            brk_seen_q <= 1'b0;
        end else begin
            rst_q      <= core_rst_d;
            txd_q      <= core_rst_d ? core_txd : IDLE_TXD;
            brk_seen_q <= brk_seen_q | brk_active;
        end
    end

    assign core_rst_n = rst_q;
    assign core_rxd   = rxd_q;
    assign pad_txd    = txd_q;
    assign brk_seen   = brk_seen_q;

    // Flash pins pass straight through so no skew is added to flash timing.
    assign spi_core = '{
        sclk: core_sclk,
        cs_n: core_cs_n,
        oe:   core_oe,
        qdo:  core_qdo
    };
    assign spi_pad  = rst_q ? spi_core : SPI_IDLE;

    assign pad_sclk = spi_pad.sclk;
    assign pad_cs_n = spi_pad.cs_n;

    for (genvar i = 0; i < QD_W; i++) begin : g_qd
        assign pad_qd[i] = spi_pad.oe[i] ? spi_pad.qdo[i] : 1'bz;
    end

    assign core_qdi = pad_qd;

endmodule

// File: tb/tb_mcu_ring.sv
// Bench for mcu_ring: directed reset/break/pad sequences plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_mcu_ring;

    localparam int unsigned R = 4;
    localparam int unsigned B = 20;

    logic       clk;
    logic       arstn;
    logic       pad_rxd;
    logic       pad_txd;
    logic       pad_sclk;
    logic       pad_cs_n;
    wire  [3:0] pad_qd;
    logic       core_rst_n;
    logic       core_rxd;
    logic       core_txd;
    logic       core_sclk;
    logic       core_cs_n;
    logic [3:0] core_qdo;
    logic [3:0] core_oe;
    logic [3:0] core_qdi;
    logic       brk_seen;

    logic [3:0] ext_en;
    logic [3:0] ext_val;

    for (genvar i = 0; i < 4; i++) begin : g_ext
        assign pad_qd[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    mcu_ring #(.RST_CYCLES(R), .BREAK_CYCLES(B)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .pad_rxd    (pad_rxd),
        .pad_txd    (pad_txd),
        .pad_sclk   (pad_sclk),
        .pad_cs_n   (pad_cs_n),
        .pad_qd     (pad_qd),
        .core_rst_n (core_rst_n),
        .core_rxd   (core_rxd),
        .core_txd   (core_txd),
        .core_sclk  (core_sclk),
        .core_cs_n  (core_cs_n),
        .core_qdo   (core_qdo),
        .core_oe    (core_oe),
        .core_qdi   (core_qdi),
        .brk_seen   (brk_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int edge_n;

    // Behavioural model state, valid after the most recent clock edge.
    logic m_rstn, m_rxd, m_brk, m_seen, m_txd;
    int   m_run;     // consecutive edges with filtered rxd low
    int   m_quiet;   // consecutive edges with no reset cause
    int   m_since;   // edges since arstn release
    logic pq[$];     // pad_rxd samples, newest first

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, edge_n, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_rstn  = 1'b0;
        m_rxd   = 1'b1;
        m_brk   = 1'b0;
        m_seen  = 1'b0;
        m_txd   = 1'b1;
        m_run   = 0;
        m_quiet = 0;
        m_since = 0;
        pq.delete();
        repeat (6) pq.push_back(1'b1);
    endfunction

    // Filtered rxd is the majority of pad samples taken 3..5 edges ago; a break
    // is B filtered-low edges in a row; core reset releases after R+1 quiet edges.
    function automatic void model_edge();
        logic rxd_n, brk_n, rstn_n, sync_n;
        int   run_n;
        pq.push_front(pad_rxd);
        while (pq.size() > 6) void'(pq.pop_back());
        rxd_n   = (int'(pq[3]) + int'(pq[4]) + int'(pq[5])) >= 2;
        run_n   = (m_rxd == 1'b0) ? m_run + 1 : 0;
        brk_n   = (run_n >= int'(B));
        m_since = m_since + 1;
        sync_n  = (m_since >= 2);
        rstn_n  = (m_quiet >= int'(R) + 1);
        m_quiet = (brk_n || !sync_n) ? 0 : m_quiet + 1;
        m_seen  = m_seen | m_brk;
        m_txd   = rstn_n ? core_txd : 1'b1;
        m_rxd   = rxd_n;
        m_run   = run_n;
        m_brk   = brk_n;
        m_rstn  = rstn_n;
    endfunction

    // External flash drives exactly the bits the ring should leave floating.
    function automatic void update_ext();
        ext_en = ~(core_oe & {4{m_rstn & arstn}});
    endfunction

    task automatic check_all();
        logic [3:0] eff, eq;
        eff = core_oe & {4{m_rstn}};
        eq  = (eff & core_qdo) | (~eff & ext_val);
        chk("core_rst_n", 4'(core_rst_n), 4'(m_rstn));
        chk("core_rxd",   4'(core_rxd),   4'(m_rxd));
        chk("brk_seen",   4'(brk_seen),   4'(m_seen));
        chk("pad_txd",    4'(pad_txd),    4'(m_txd));
        chk("pad_sclk",   4'(pad_sclk),   4'(m_rstn ? core_sclk : 1'b0));
        chk("pad_cs_n",   4'(pad_cs_n),   4'(m_rstn ? core_cs_n : 1'b1));
        chk("pad_qd",     pad_qd,         eq);
        chk("core_qdi",   core_qdi,       eq);
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!arstn) model_reset();
        else        model_edge();
        update_ext();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic [3:0] oe;
        logic [3:0] qdo;
        logic [3:0] ext;
        logic       sclk;
        logic       cs_n;
        logic [3:0] exp_qd;
        logic       exp_sclk;
        logic       exp_cs_n;
    } vec_t;

    vec_t vecs[6];
    logic saw_low;
    logic lvl;
    int   run_left;
    int   rst_left;

    initial begin
        vecs[0] = '{oe:4'b0101, qdo:4'b1111, ext:4'b0000, sclk:1'b1, cs_n:1'b0, exp_qd:4'b0101, exp_sclk:1'b1, exp_cs_n:1'b0};
        vecs[1] = '{oe:4'b1010, qdo:4'b0000, ext:4'b1111, sclk:1'b0, cs_n:1'b1, exp_qd:4'b0101, exp_sclk:1'b0, exp_cs_n:1'b1};
        vecs[2] = '{oe:4'b1111, qdo:4'b1001, ext:4'b0110, sclk:1'b1, cs_n:1'b1, exp_qd:4'b1001, exp_sclk:1'b1, exp_cs_n:1'b1};
        vecs[3] = '{oe:4'b0000, qdo:4'b1111, ext:4'b0110, sclk:1'b0, cs_n:1'b0, exp_qd:4'b0110, exp_sclk:1'b0, exp_cs_n:1'b0};
        vecs[4] = '{oe:4'b0011, qdo:4'b0001, ext:4'b1100, sclk:1'b1, cs_n:1'b0, exp_qd:4'b1101, exp_sclk:1'b1, exp_cs_n:1'b0};
        vecs[5] = '{oe:4'b1000, qdo:4'b0111, ext:4'b0010, sclk:1'b0, cs_n:1'b1, exp_qd:4'b0010, exp_sclk:1'b0, exp_cs_n:1'b1};

        n_vec = 0; n_err = 0; edge_n = 0;
        arstn = 1'b0; pad_rxd = 1'b1;
        core_txd = 1'b0; core_sclk = 1'b1; core_cs_n = 1'b0;
        core_oe = 4'hF; core_qdo = 4'hF; ext_val = 4'h0;
        model_reset();
        update_ext();

        // Held in reset: every pin at its idle level despite active core inputs.
        @(negedge clk);
        chk("rst_core_rst_n", 4'(core_rst_n), 4'd0);
        chk("rst_cs_n",       4'(pad_cs_n),   4'd1);
        chk("rst_sclk",       4'(pad_sclk),   4'd0);
        chk("rst_txd",        4'(pad_txd),    4'd1);
        chk("rst_rxd",        4'(core_rxd),   4'd1);
        chk("rst_brk_seen",   4'(brk_seen),   4'd0);
        chk("rst_qd",         pad_qd,         4'b0000);
        step(); step();

        // Release: core reset rises exactly 2+R+1 edges later.
        arstn = 1'b1; edge_n = 0; update_ext();
        repeat (7) begin
            step();
            if (edge_n == 6) begin
                chk("rel_hold",     4'(core_rst_n), 4'd0);
                chk("rel_idle_cs",  4'(pad_cs_n),   4'd1);
                chk("rel_idle_clk", 4'(pad_sclk),   4'd0);
                chk("rel_idle_qd",  pad_qd,         4'b0000);
            end
        end
        chk("rel_rise", 4'(core_rst_n), 4'd1);
        chk("rel_seen", 4'(brk_seen),   4'd0);

        // rxd latency, single-sample glitch, then a full break.
        core_oe = 4'h0; update_ext();
        while (edge_n < 10) step();
        pad_rxd = 1'b0;
        while (edge_n < 15) begin
            step();
            if (edge_n == 14) chk("rxd_lat_hold", 4'(core_rxd), 4'd1);
        end
        chk("rxd_lat_fall", 4'(core_rxd), 4'd0);
        while (edge_n < 45) begin
            pad_rxd = (edge_n == 30) ? 1'b1 : 1'b0;
            step();
            chk("rxd_glitch", 4'(core_rxd), 4'd0);
            if (edge_n == 35) chk("brk_pre", 4'(core_rst_n), 4'd1);
            if (edge_n == 36) begin
                chk("brk_rst",  4'(core_rst_n), 4'd0);
                chk("brk_seen", 4'(brk_seen),   4'd1);
            end
            if (edge_n == 40) chk("brk_txd_idle", 4'(pad_txd), 4'd1);
        end
        pad_rxd = 1'b1;
        while (edge_n < 56) begin
            step();
            if (edge_n == 55) chk("brk_hold", 4'(core_rst_n), 4'd0);
        end
        chk("brk_release", 4'(core_rst_n), 4'd1);
        chk("brk_sticky",  4'(brk_seen),   4'd1);

        // txd follows with one register of delay.
        for (int i = 0; i < 8; i++) begin
            core_txd = i[0];
            step();
            chk("txd_follow", 4'(pad_txd), 4'(i[0]));
        end

        // Pad steering table.
        for (int i = 0; i < 6; i++) begin
            core_oe = vecs[i].oe; core_qdo = vecs[i].qdo; ext_val = vecs[i].ext;
            core_sclk = vecs[i].sclk; core_cs_n = vecs[i].cs_n;
            update_ext();
            #1;
            chk("tbl_qd",   pad_qd,         vecs[i].exp_qd);
            chk("tbl_qdi",  core_qdi,       vecs[i].exp_qd);
            chk("tbl_sclk", 4'(pad_sclk),   4'(vecs[i].exp_sclk));
            chk("tbl_cs_n", 4'(pad_cs_n),   4'(vecs[i].exp_cs_n));
            step();
        end

        // Asynchronous reset in the middle of a transfer.
        core_oe = 4'b0101; core_qdo = 4'hF; ext_val = 4'h0;
        core_sclk = 1'b1; core_cs_n = 1'b0; core_txd = 1'b0;
        update_ext();
        step();
        chk("mid_qd",  pad_qd,       4'b0101);
        chk("mid_qdi", core_qdi,     4'b0101);
        chk("mid_txd", 4'(pad_txd),  4'd0);
        #2;
        arstn = 1'b0; update_ext();
        #1;
        chk("async_rst_n", 4'(core_rst_n), 4'd0);
        chk("async_qd",    pad_qd,         4'b0000);
        chk("async_cs_n",  4'(pad_cs_n),   4'd1);
        chk("async_sclk",  4'(pad_sclk),   4'd0);
        chk("async_txd",   4'(pad_txd),    4'd1);
        step(); step();
        arstn = 1'b1; edge_n = 0; update_ext();
        while (edge_n < 7) step();
        chk("rerel_rise", 4'(core_rst_n), 4'd1);
        chk("rerel_seen", 4'(brk_seen),   4'd0);

        // Break one sample short of the threshold: no effect.
        saw_low = 1'b0;
        pad_rxd = 1'b0;
        repeat (19) begin step(); if (!core_rst_n) saw_low = 1'b1; end
        pad_rxd = 1'b1;
        repeat (30) begin step(); if (!core_rst_n) saw_low = 1'b1; end
        chk("short_brk_rst",  4'(saw_low),  4'd0);
        chk("short_brk_seen", 4'(brk_seen), 4'd0);

        // Break exactly at the threshold: resets the core.
        saw_low = 1'b0;
        pad_rxd = 1'b0;
        repeat (20) begin step(); if (!core_rst_n) saw_low = 1'b1; end
        pad_rxd = 1'b1;
        repeat (30) begin step(); if (!core_rst_n) saw_low = 1'b1; end
        chk("exact_brk_rst",  4'(saw_low),  4'd1);
        chk("exact_brk_seen", 4'(brk_seen), 4'd1);

        // Randomized traffic with long rxd lows and occasional async resets.
        lvl = pad_rxd; run_left = 0; rst_left = 0;
        for (int c = 0; c < 900; c++) begin
            core_txd  = 1'($urandom);
            core_sclk = 1'($urandom);
            core_cs_n = 1'($urandom);
            core_oe   = 4'($urandom);
            core_qdo  = 4'($urandom);
            ext_val   = 4'($urandom);
            if (run_left == 0) begin
                lvl = ~lvl;
                run_left = lvl ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 26));
            end
            pad_rxd = lvl;
            run_left--;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) arstn = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                arstn = 1'b0;
                rst_left = int'($urandom_range(1, 3));
            end
            update_ext();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
